// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types and the memory-responder FSM state encoding.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } lc3b_memresp_state;

endpackage

// File: rtl/lc3b_mem_array.sv
// Word-organised storage: registered read port with enable, byte-masked write port.
module lc3b_mem_array
    import lc3b_types::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_en_i,
    input  logic [DEPTH_LOG2-1:0] rd_idx_i,
    output lc3b_word              rdata_o,
    input  logic                  wr_en_i,
    input  logic [DEPTH_LOG2-1:0] wr_idx_i,
    input  lc3b_word              wdata_i,
    input  lc3b_mem_wmask         wmask_i
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    lc3b_word mem_q [DEPTH];
    lc3b_word rdata_q;

    // NOTE: the storage array is deliberately left without reset so it maps onto RAM and keeps its contents.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            if (wmask_i[0]) mem_q[wr_idx_i][7:0]  <= wdata_i[7:0];
            if (wmask_i[1]) mem_q[wr_idx_i][15:8] <= wdata_i[15:8];
        end
    end

    // The read register holds its value between reads; only it is cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[rd_idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lc3b_mem_responder.sv
// Fixed-latency memory responder: request capture, latency counter, protocol checks,
// transaction counter, wrapped around a byte-writable word array.
module lc3b_mem_responder
    import lc3b_types::*;
#(
    parameter int LATENCY    = 3,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_read,
    input  logic          mem_write,
    input  lc3b_word      mem_address,
    input  lc3b_word      mem_wdata,
    input  lc3b_mem_wmask mem_byte_enable,
    output logic          mem_resp,
    output lc3b_word      mem_rdata,
    output logic          protocol_err,
    output logic [15:0]   xact_count
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    lc3b_memresp_state state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    lc3b_word          addr_q, addr_d;
    lc3b_word          wdata_q, wdata_d;
    lc3b_mem_wmask     be_q, be_d;
    logic              is_write_q, is_write_d;
    logic              err_q, err_d;
    logic [15:0]       count_q, count_d;

    logic                  rd_en;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  op_held;
    logic                  inputs_changed;

    assign op_held        = is_write_q ? mem_write : mem_read;
    assign inputs_changed = (mem_address != addr_q) || (mem_wdata != wdata_q) ||
                            (mem_byte_enable != be_q);

    // NOTE: every signal written here gets its default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        is_write_d = is_write_q;
        err_d      = err_q;
        count_d    = count_q;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        rd_idx     = addr_q[DEPTH_LOG2:1];

        unique case (state_q)
            IDLE: begin
                rd_idx = mem_address[DEPTH_LOG2:1];
                if (mem_read && mem_write) begin
                    err_d = 1'b1;
                end else if (mem_read || mem_write) begin
                    addr_d     = mem_address;
                    wdata_d    = mem_wdata;
                    be_d       = mem_byte_enable;
                    is_write_d = mem_write;
                    cnt_d      = CNT_LOAD;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        rd_en   = mem_read;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (inputs_changed) err_d = 1'b1;
                if (!op_held) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                    rd_en   = !is_write_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                count_d = count_q + 16'd1;
                wr_en   = is_write_q && (be_q != 2'b00);
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            is_write_q <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            is_write_q <= is_write_d;
            err_q      <= err_d;
            count_q    <= count_d;
        end
    end

    // Reset during RESP abandons the transaction, so it also masks the pulse and the write.
    lc3b_mem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_en_i  (rd_en && !reset),
        .rd_idx_i (rd_idx),
        .rdata_o  (mem_rdata),
        .wr_en_i  (wr_en && !reset),
        .wr_idx_i (addr_q[DEPTH_LOG2:1]),
        .wdata_i  (wdata_q),
        .wmask_i  (be_q)
    );

    assign mem_resp     = (state_q == RESP) && !reset;
    assign protocol_err = err_q;
    assign xact_count   = count_q;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Bench for lc3b_mem_responder: directed scenarios plus random traffic against a word-array model.
module tb_lc3b_mem_responder;
    import lc3b_types::*;

    localparam int LAT   = 3;
    localparam int DL2   = 8;
    localparam int WORDS = 1 << DL2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          rd, wr;
    lc3b_word      addr, wdata;
    lc3b_mem_wmask be;
    logic          resp, err;
    lc3b_word      rdata;
    logic [15:0]   xcnt;

    logic          rd1, wr1;
    lc3b_word      addr1, wdata1;
    lc3b_mem_wmask be1;
    logic          resp1, err1;
    lc3b_word      rdata1;
    logic [15:0]   xcnt1;

    lc3b_mem_responder #(.LATENCY(LAT), .DEPTH_LOG2(DL2)) u_dut (
        .clk(clk), .reset(reset), .mem_read(rd), .mem_write(wr), .mem_address(addr),
        .mem_wdata(wdata), .mem_byte_enable(be), .mem_resp(resp), .mem_rdata(rdata),
        .protocol_err(err), .xact_count(xcnt)
    );

    lc3b_mem_responder #(.LATENCY(1), .DEPTH_LOG2(DL2)) u_dut1 (
        .clk(clk), .reset(reset), .mem_read(rd1), .mem_write(wr1), .mem_address(addr1),
        .mem_wdata(wdata1), .mem_byte_enable(be1), .mem_resp(resp1), .mem_rdata(rdata1),
        .protocol_err(err1), .xact_count(xcnt1)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mdl    [WORDS];
    bit          mdl_ok [WORDS];
    int          exp_count = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int widx(input lc3b_word a);
        return (int'(a) / 2) % WORDS;
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        exp_count = 0;
    endtask

    // Returns cycles until mem_resp is seen, counting the acceptance cycle; -1 on timeout.
    task automatic wait_resp(output int lat);
        lat = 0;
        do begin
            cycle();
            lat++;
        end while (!resp && lat < 20);
        if (!resp) lat = -1;
    endtask

    task automatic model_write(input lc3b_word a, input lc3b_word d, input lc3b_mem_wmask b);
        int i;
        i = widx(a);
        if (b[0]) mdl[i][7:0]  = d[7:0];
        if (b[1]) mdl[i][15:8] = d[15:8];
        mdl_ok[i] = mdl_ok[i] || (b == 2'b11);
    endtask

    task automatic do_xact(input string tag, input bit is_wr, input lc3b_word a,
                           input lc3b_word d, input lc3b_mem_wmask b);
        int lat;
        int i;
        addr = a; wdata = d; be = b; rd = !is_wr; wr = is_wr;
        wait_resp(lat);
        check({tag, "_lat"}, lat, LAT);
        i = widx(a);
        if (!is_wr && mdl_ok[i]) check({tag, "_rdata"}, rdata, mdl[i]);
        rd = 1'b0; wr = 1'b0;
        if (lat > 0) begin
            if (is_wr) model_write(a, d, b);
            exp_count = (exp_count + 1) % 65536;
        end
        cycle();
        check({tag, "_count"}, xcnt, exp_count);
    endtask

    initial begin
        int  lat;
        int  base;
        bit  seen;
        lc3b_word ra;

        reset = 1'b1;
        rd = 0; wr = 0; addr = '0; wdata = '0; be = '0;
        rd1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0; be1 = '0;
        for (int i = 0; i < WORDS; i++) begin
            mdl[i] = '0;
            mdl_ok[i] = 1'b0;
        end
        @(negedge clk);
        do_reset();
        check("rst_resp", resp, 0);
        check("rst_rdata", rdata, 16'h0000);
        check("rst_err", err, 0);
        check("rst_count", xcnt, 0);

        do_xact("w_beef", 1, 16'h0010, 16'hBEEF, 2'b11);
        do_xact("r_beef", 0, 16'h0010, 16'h0000, 2'b11);
        check("beef_data", rdata, 16'hBEEF);
        check("beef_count", xcnt, 2);

        do_xact("w_1234", 1, 16'h0030, 16'h1234, 2'b11);
        do_xact("w_ab00", 1, 16'h0030, 16'hAB00, 2'b10);
        do_xact("r_ab34", 0, 16'h0030, 16'h0000, 2'b11);
        check("mask_data", rdata, 16'hAB34);
        do_xact("w_be00", 1, 16'h0031, 16'hFFFF, 2'b00);
        do_xact("r_be00", 0, 16'h0030, 16'h0000, 2'b11);
        check("be00_data", rdata, 16'hAB34);

        do_xact("w_alias", 1, 16'h0020, 16'hC0DE, 2'b11);
        do_xact("r_alias", 0, 16'h0220, 16'h0000, 2'b11);
        check("alias_data", rdata, 16'hC0DE);

        for (int w = 8; w < 16; w++)
            do_xact("prefill", 1, 16'(w * 2), 16'($urandom), 2'b11);
        for (int n = 0; n < 40; n++) begin
            ra = 16'(($urandom_range(0, 127) << 9) | ((8 + $urandom_range(0, 7)) << 1) |
                     $urandom_range(0, 1));
            do_xact("rand", 1'($urandom_range(0, 1)), ra, 16'($urandom),
                    2'($urandom_range(0, 3)));
        end

        // Read dropped in the second BUSY cycle.
        base = exp_count;
        rd = 1'b1; addr = 16'h0010;
        cycle();
        check("abort_busy1", resp, 0);
        cycle();
        check("abort_busy2", resp, 0);
        rd = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            seen = seen | resp;
        end
        check("abort_noresp", seen, 0);
        check("abort_count", xcnt, base);

        // Write dropped mid-BUSY must leave memory untouched.
        wr = 1'b1; addr = 16'h0010; wdata = 16'hDEAD; be = 2'b11;
        cycle();
        cycle();
        wr = 1'b0;
        repeat (4) cycle();
        do_xact("r_after_abort", 0, 16'h0010, 16'h0000, 2'b11);

        // Inputs changed mid-BUSY: flag raised, captured values still used.
        check("err_before", err, 0);
        wr = 1'b1; addr = 16'h0040; wdata = 16'h7777; be = 2'b11;
        cycle();
        addr = 16'h0042; wdata = 16'h0000; be = 2'b01;
        wait_resp(lat);
        check("chg_lat", (lat > 0) ? lat + 1 : lat, LAT);
        check("chg_err", err, 1);
        wr = 1'b0;
        if (lat > 0) begin
            model_write(16'h0040, 16'h7777, 2'b11);
            exp_count++;
        end
        cycle();
        do_xact("r_chg", 0, 16'h0040, 16'h0000, 2'b11);
        check("chg_data", rdata, 16'h7777);
        check("err_sticky", err, 1);

        do_reset();
        check("rst2_err", err, 0);
        check("rst2_rdata", rdata, 16'h0000);

        // Both request lines together.
        rd = 1'b1; wr = 1'b1; addr = 16'h0040;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            seen = seen | resp;
        end
        check("both_err", err, 1);
        check("both_noresp", seen, 0);
        check("both_count", xcnt, 0);
        rd = 1'b0; wr = 1'b0;
        cycle();
        do_xact("r_after_both", 0, 16'h0040, 16'h0000, 2'b11);
        check("both_err_held", err, 1);

        // Reset during BUSY of a write abandons it.
        do_reset();
        do_xact("w_prior", 1, 16'h0060, 16'h1111, 2'b11);
        wr = 1'b1; addr = 16'h0060; wdata = 16'h5555; be = 2'b11;
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0; wr = 1'b0;
        exp_count = 0;
        check("midrst_rdata", rdata, 16'h0000);
        check("midrst_count", xcnt, 0);
        check("midrst_resp", resp, 0);
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            seen = seen | resp;
        end
        check("midrst_noresp", seen, 0);
        do_xact("r_prior", 0, 16'h0060, 16'h0000, 2'b11);
        check("prior_data", rdata, 16'h1111);

        // LATENCY=1 instance: single write, then held read pulses every other cycle.
        wr1 = 1'b1; addr1 = 16'h0080; wdata1 = 16'h4242; be1 = 2'b11;
        cycle();
        check("l1_wr_resp", resp1, 1);
        wr1 = 1'b0;
        cycle();
        check("l1_wr_done", resp1, 0);
        rd1 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            check("l1_b2b_resp", resp1, (k % 2 == 1) ? 1 : 0);
            if (k % 2 == 1) check("l1_b2b_rdata", rdata1, 16'h4242);
        end
        rd1 = 1'b0;
        cycle();
        check("l1_count", xcnt1, 5);
        check("l1_err", err1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
